// File: rtl/quad_encoder_counter.sv
// -----------------------------------------------------------------------------
// quad_encoder_counter
//
// Quadrature encoder front end: 2-flop synchronisers on A/B (and Z), a
// per-channel stability filter, Gray-code transition decoding at x1/x2/x4
// resolution, a wrapping or saturating position counter, and a registered
// hex 7-segment decode of the counter's low nibble.
//
// Optional feature: define ENC_INDEX_EN to make a rising edge of the
// synchronised index input Z load the counter with zero. Without the macro
// Z is ignored and no index logic exists.
// -----------------------------------------------------------------------------
module quad_encoder_counter #(
  parameter int CNT_W      = 8,
  parameter int CNT_MAX    = 2**CNT_W - 1,
  parameter int DEB_CYCLES = 4,
  parameter bit SATURATE   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,       // asynchronous, active-low
  input  logic             a,
  input  logic             b,
  input  logic             z,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic [6:0]       segments
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

  // Resolution selector; 2'b11 behaves like x4.
  typedef enum logic [1:0] {
    MODE_X1 = 2'b00,
    MODE_X2 = 2'b01,
    MODE_X4 = 2'b10
  } mode_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Position of a Gray code {A,B} along the CW cycle 00,01,11,10 (0..3).
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Hex digit to active-high segments, bit0 = seg a ... bit6 = seg g.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Synchronisers: bit1 = A, bit0 = B
  // ---------------------------------------------------------------------------
  logic [1:0] ab_s1_q, ab_s2_q;

  // Two-flop synchroniser for the asynchronous encoder channels.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ab_s1_q <= 2'b00;
      ab_s2_q <= 2'b00;
    end else begin
      ab_s1_q <= {a, b};
      ab_s2_q <= ab_s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stability filter: a channel follows its synced value only after the
  // difference has persisted for DEB_CYCLES consecutive cycles.
  // ---------------------------------------------------------------------------
  logic [1:0] ab_f;

  if (DEB_CYCLES == 0) begin : g_bypass
    assign ab_f = ab_s2_q;
  end else begin : g_deb
    localparam int              DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic [DEB_W-1:0] cnt_q, cnt_d;
      logic             filt_q, filt_d;

      // Count mismatch cycles; the DEB_CYCLES-th one commits the new value.
      // NOTE: every always_comb output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (ab_s2_q[ch] != filt_q) begin
          if (cnt_q == DEB_LAST) begin
            filt_d = ab_s2_q[ch];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Filter state register.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign ab_f[ch] = filt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional index input
  // ---------------------------------------------------------------------------
  logic index_rise;

`ifdef ENC_INDEX_EN
  logic z_s1_q, z_s2_q, z_prev_q;

  // Synchronise Z and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z_s1_q   <= 1'b0;
      z_s2_q   <= 1'b0;
      z_prev_q <= 1'b0;
    end else begin
      z_s1_q   <= z;
      z_s2_q   <= z_s1_q;
      z_prev_q <= z_s2_q;
    end
  end

  assign index_rise = z_s2_q & ~z_prev_q;
`else
  logic unused_z;
  assign unused_z   = z;
  assign index_rise = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Transition decode
  // ---------------------------------------------------------------------------
  logic [1:0] prev_q;
  logic [1:0] delta;
  logic       moved, illegal, up, qualified, count_en;
  mode_e      mode_sel;

  assign mode_sel = (mode == 2'b11) ? MODE_X4 : mode_e'(mode);

  // Classify the filtered transition and apply the resolution filter.
  always_comb begin
    delta   = gray_pos(ab_f) - gray_pos(prev_q);   // 1 = CW, 3 = CCW, 2 = illegal
    moved   = (delta != 2'd0);
    illegal = (delta == 2'd2);
    up      = (delta == 2'd1);
    case (mode_sel)
      MODE_X1: qualified = (ab_f == 2'b00);
      MODE_X2: qualified = (ab_f[1] != prev_q[1]);
      default: qualified = 1'b1;
    endcase
    count_en = moved && !illegal && qualified;
  end

  // ---------------------------------------------------------------------------
  // Position counter, direction, step pulse, sticky error
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  // Next-state for the counter block; clr has the last word, then index.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = err_q | illegal;

    if (count_en) begin
      step_d = 1'b1;
      dir_d  = up;
      if (up) begin
        if (count_q >= MAX_V) begin
          count_d = SATURATE ? MAX_V : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = SATURATE ? '0 : MAX_V;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end

    if (index_rise) begin
      count_d = '0;
    end

    if (clr) begin
      count_d = '0;
      err_d   = 1'b0;
      step_d  = 1'b0;
      dir_d   = dir_q;
    end
  end

  // Decoder history and counter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= 2'b00;
      count_q <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= ab_f;
      count_q <= count_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Segment display: registered, one cycle behind count
  // ---------------------------------------------------------------------------
  logic [3:0] nibble;
  logic [6:0] seg_q;

  assign nibble = 4'(count_q);

  // Register the hex decode of the low nibble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= 7'h3F;
    end else begin
      seg_q <= hex7(nibble);
    end
  end

  assign count    = count_q;
  assign dir      = dir_q;
  assign step     = step_q;
  assign err      = err_q;
  assign segments = seg_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// -----------------------------------------------------------------------------
// tb_quad_encoder_counter
//
// Two instances share the same pins: u_wrap (defaults, 8-bit wrapping) and
// u_sat (saturating, CNT_MAX = 9). A reference model tracks the encoder's
// phase on the Gray cycle and applies the counting rules to both counters.
// Respects ENC_INDEX_EN when computing the index expectation.
// -----------------------------------------------------------------------------
module tb_quad_encoder_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, b, z, clr;
  logic [1:0] mode;

  logic [7:0] count0, count1;
  logic       dir0, dir1, step0, step1, err0, err1;
  logic [6:0] seg0, seg1;

  always #5 clk = ~clk;

  quad_encoder_counter u_wrap (
    .clk(clk), .rst(rst), .a(a), .b(b), .z(z), .mode(mode), .clr(clr),
    .count(count0), .dir(dir0), .step(step0), .err(err0), .segments(seg0)
  );

  quad_encoder_counter #(
    .CNT_W(8), .CNT_MAX(9), .DEB_CYCLES(4), .SATURATE(1'b1)
  ) u_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .z(z), .mode(mode), .clr(clr),
    .count(count1), .dir(dir1), .step(step1), .err(err1), .segments(seg1)
  );

  // Reference data
  logic [1:0] gray_seq [4]  = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [6:0] seg_tab  [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int m_phase, m_cnt0, m_cnt1, m_steps;
  bit m_dir, m_err;
  int steps0 = 0, steps1 = 0;
  int checks = 0, errors = 0;

  // Count step pulses seen on each instance.
  always @(negedge clk) begin
    if (step0 === 1'b1) steps0++;
    if (step1 === 1'b1) steps1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt0 = 0; m_cnt1 = 0; m_dir = 1'b0; m_err = 1'b0;
  endtask

  // Apply the counting rules for a move of the encoder to new_phase.
  task automatic model_apply(input int new_phase);
    int         d;
    bit         counted;
    logic [1:0] oc, nc;
    oc = gray_seq[m_phase];
    nc = gray_seq[new_phase];
    d  = (new_phase - m_phase + 4) % 4;
    counted = 1'b0;
    if (d == 2) begin
      m_err = 1'b1;
    end else if (d != 0) begin
      case (mode)
        2'b00:   counted = (nc == 2'b00);
        2'b01:   counted = (nc[1] != oc[1]);
        default: counted = 1'b1;
      endcase
    end
    if (counted) begin
      m_steps++;
      if (d == 1) begin
        m_cnt0 = (m_cnt0 + 1) % 256;
        m_cnt1 = (m_cnt1 < 9) ? m_cnt1 + 1 : 9;
        m_dir  = 1'b1;
      end else begin
        m_cnt0 = (m_cnt0 + 255) % 256;
        m_cnt1 = (m_cnt1 > 0) ? m_cnt1 - 1 : 0;
        m_dir  = 1'b0;
      end
    end
    m_phase = new_phase;
  endtask

  task automatic drive_phase(input int p, input int hold);
    model_apply(p);
    {a, b} = gray_seq[p];
    repeat (hold) @(negedge clk);
  endtask

  task automatic moves(input int n, input bit cw);
    for (int i = 0; i < n; i++) drive_phase((m_phase + (cw ? 1 : 3)) % 4, 10);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_cnt0 = 0; m_cnt1 = 0; m_err = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    #1;
    check({tag, "/count_wrap"}, count0, m_cnt0);
    check({tag, "/count_sat"},  count1, m_cnt1);
    check({tag, "/dir_wrap"},   dir0, m_dir);
    check({tag, "/dir_sat"},    dir1, m_dir);
    check({tag, "/err_wrap"},   err0, m_err);
    check({tag, "/err_sat"},    err1, m_err);
    check({tag, "/seg_wrap"},   seg0, seg_tab[m_cnt0 % 16]);
    check({tag, "/seg_sat"},    seg1, seg_tab[m_cnt1 % 16]);
    check({tag, "/steps_wrap"}, steps0, m_steps);
    check({tag, "/steps_sat"},  steps1, m_steps);
  endtask

  // Watchdog: the directed sequence has no open-ended waits, this is a backstop.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saved_dir;
    int saved_steps;

    rst = 1'b0; a = 1'b0; b = 1'b0; z = 1'b0; clr = 1'b0; mode = 2'b10;
    m_steps = 0;
    model_reset();

    // Reset held while the pins toggle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {a, b} = 2'($urandom_range(3, 0));
    end
    #1;
    check("reset/count", count0, 0);
    check("reset/seg",   seg0, 7'h3F);
    check("reset/err",   err0, 0);
    check("reset/step",  step0, 0);
    check("reset/dir",   dir0, 0);
    {a, b} = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // First CW step: count changes on the 7th edge, segments on the 8th.
    model_apply(1);
    {a, b} = gray_seq[1];
    repeat (6) @(negedge clk);
    #1;
    check("latency/count_before", count0, 0);
    check("latency/step_before",  step0, 0);
    @(negedge clk);
    #1;
    check("latency/count_at7", count0, 1);
    check("latency/step_at7",  step0, 1);
    check("latency/dir_at7",   dir0, 1);
    @(negedge clk);
    #1;
    check("latency/seg_at8", seg0, 7'h06);
    repeat (3) @(negedge clk);
    check_all("first_step");

    // x4: 16 CW transitions in total, then 17 CCW wraps below zero.
    moves(15, 1'b1);
    check_all("x4_cw16");
    moves(17, 1'b0);
    check_all("x4_ccw17");
    check("x4_wrap/count255", count0, 8'd255);

    // x1 then x2, one CW cycle each from zero.
    clr_pulse();
    check_all("clr_after_wrap");
    mode = 2'b00;
    moves(4, 1'b1);
    check_all("x1_cycle");
    mode = 2'b01;
    moves(4, 1'b1);
    check_all("x2_cycle");
    check("x2_cycle/count3", count0, 3);

    // Saturation: 12 CW x4 transitions from zero.
    mode = 2'b10;
    clr_pulse();
    saved_steps = steps1;
    moves(12, 1'b1);
    check_all("sat_12cw");
    check("sat/seg_6F",  seg1, 7'h6F);
    check("sat/pulses",  steps1 - saved_steps, 12);

    // Short glitch on A is filtered out.
    a = ~a;
    repeat (3) @(negedge clk);
    a = ~a;
    repeat (8) @(negedge clk);
    check_all("glitch3");

    // Both channels jump together: illegal, sticky error, no count.
    drive_phase((m_phase + 2) % 4, 10);
    check_all("illegal_jump");
    drive_phase((m_phase + 1) % 4, 10);
    check_all("err_sticky");
    clr_pulse();
    check_all("clr_clears_err");

    // clr in the same cycle as a step: clear wins, no pulse, dir held.
    moves(2, 1'b1);
    saved_dir   = m_dir;
    saved_steps = m_steps;
    model_apply((m_phase + 3) % 4);
    {a, b} = gray_seq[m_phase];
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    #1;
    check("clr_vs_step/count", count0, 0);
    check("clr_vs_step/step",  step0, 0);
    check("clr_vs_step/dir",   dir0, saved_dir);
    clr = 1'b0;
    m_cnt0 = 0; m_cnt1 = 0; m_err = 1'b0; m_dir = saved_dir; m_steps = saved_steps;
    repeat (3) @(negedge clk);
    check_all("clr_vs_step");

    // Index pulse at count 37.
    moves(37, 1'b1);
    check_all("pre_index");
    z = 1'b1;
    repeat (3) @(negedge clk);
    z = 1'b0;
`ifdef ENC_INDEX_EN
    m_cnt0 = 0; m_cnt1 = 0;
`endif
    repeat (5) @(negedge clk);
    check_all("index");

    // Randomised traffic: mixed modes, directions, hold times, rare illegal
    // jumps and clears.
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(15, 0));
      if (r == 0) mode = 2'($urandom_range(3, 0));
      if (r == 1) begin
        clr_pulse();
      end else if (r == 2) begin
        drive_phase((m_phase + 2) % 4, int'($urandom_range(14, 9)));
      end else begin
        drive_phase((m_phase + (($urandom_range(1, 0) == 1) ? 1 : 3)) % 4,
                    int'($urandom_range(14, 9)));
      end
      check_all("random");
    end

    // Reset with the pins parked at 10: first transition decodes against 00.
    mode = 2'b10;
    while (m_phase != 3) drive_phase((m_phase + 1) % 4, 10);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("midreset/count", count0, 0);
    check("midreset/seg",   seg0, 7'h3F);
    rst = 1'b1;
    model_reset();
    model_apply(3);
    repeat (10) @(negedge clk);
    check_all("midreset_decode");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
